// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX/MEM hazard inputs and front-end control outputs of the hazard controller
interface hazard_ctrl_if;
    logic [1:0] fwdEn_ID;
    logic [4:0] Rn_ID;
    logic [4:0] Rm_ID;
    logic [4:0] Rd_ID;
    logic       cbz_ID;
    logic       bcond_ID;
    logic       brTaken_ID;
    logic       MemRead_EX;
    logic       RegWrite_EX;
    logic       flagSet_EX;
    logic [4:0] targetReg_EX;
    logic       MemRead_MEM;
    logic [4:0] targetReg_MEM;
    logic       PCWrite;
    logic       IFID_write;
    logic       IFID_flush;
    logic       IDEX_bubble;
    logic       stall;
    modport master (
        output fwdEn_ID, Rn_ID, Rm_ID, Rd_ID, cbz_ID, bcond_ID, brTaken_ID,
               MemRead_EX, RegWrite_EX, flagSet_EX, targetReg_EX, MemRead_MEM, targetReg_MEM,
        input  PCWrite, IFID_write, IFID_flush, IDEX_bubble, stall
    );
    modport slave (
        input  fwdEn_ID, Rn_ID, Rm_ID, Rd_ID, cbz_ID, bcond_ID, brTaken_ID,
               MemRead_EX, RegWrite_EX, flagSet_EX, targetReg_EX, MemRead_MEM, targetReg_MEM,
        output PCWrite, IFID_write, IFID_flush, IDEX_bubble, stall
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush control for hazards forwarding cannot resolve.
// HAZARD_PERF_EN adds saturating stallCount/flushCount outputs.
module hazard_ctrl #(
    parameter logic [4:0] ZERO_REG = 5'd31
`ifdef HAZARD_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic clk,
    input  logic reset,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    , output logic [CNT_W-1:0] stallCount
    , output logic [CNT_W-1:0] flushCount
`endif
);
    typedef enum logic {RUN, HOLD} state_t;
    state_t state, state_nxt;
    logic rn_src, rm_src, rd_src, load_use, cbz_ld, req1, stall_c, flush_c;

    function automatic logic match(input logic [4:0] x, input logic [4:0] r);
        return (x != ZERO_REG) && (x == r);
    endfunction

    always_ff @(posedge clk)
        state <= reset ? RUN : state_nxt;

    always_comb begin
        rn_src    = hz.fwdEn_ID[1] | (hz.fwdEn_ID == 2'b01);
        rm_src    = hz.fwdEn_ID == 2'b11;
        rd_src    = hz.fwdEn_ID == 2'b01;
        load_use  = hz.MemRead_EX & ((rn_src & match(hz.targetReg_EX, hz.Rn_ID)) |
                                     (rm_src & match(hz.targetReg_EX, hz.Rm_ID)) |
                                     (rd_src & match(hz.targetReg_EX, hz.Rd_ID)));
        cbz_ld    = hz.cbz_ID & hz.MemRead_EX & match(hz.targetReg_EX, hz.Rd_ID);
        req1      = (hz.cbz_ID & hz.RegWrite_EX & match(hz.targetReg_EX, hz.Rd_ID)) |
                    (hz.cbz_ID & hz.MemRead_MEM & match(hz.targetReg_MEM, hz.Rd_ID)) |
                    load_use | (hz.bcond_ID & hz.flagSet_EX);
        // HOLD stalls unconditionally; reset forces the same frozen front end plus a flush
        stall_c   = reset | (state == HOLD) | cbz_ld | req1;
        flush_c   = reset | (~stall_c & hz.brTaken_ID);
        state_nxt = (state == RUN && cbz_ld) ? HOLD : RUN;
        hz.PCWrite     = ~stall_c;
        hz.IFID_write  = ~stall_c;
        hz.IDEX_bubble = stall_c;
        hz.stall       = stall_c;
        hz.IFID_flush  = flush_c;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk)
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stall_c && !(&stallCount)) stallCount <= stallCount + 1'b1;
            if (flush_c && !(&flushCount)) flushCount <= flushCount + 1'b1;
        end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven directed vectors for hazard_ctrl, plus counter sequences when HAZARD_PERF_EN
module tb_hazard_ctrl;
    typedef struct {
        logic       rst;
        logic [1:0] fwd;
        logic [4:0] rn, rm, rd;
        logic       cbz, bcond, br, mr_ex, rw_ex, fs_ex;
        logic [4:0] tr_ex;
        logic       mr_mem;
        logic [4:0] tr_mem;
        logic [4:0] exp;
    } vec_t;

    localparam logic [4:0] RUNO = 5'b11000;
    localparam logic [4:0] FLSH = 5'b11100;
    localparam logic [4:0] STL  = 5'b00011;
    localparam logic [4:0] RSTO = 5'b00111;

    logic clk = 0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t v[$];
    logic [4:0] act;

    hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
    logic [3:0] stall_cnt, flush_cnt;
    hazard_ctrl #(.ZERO_REG(5'd31), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .hz(hz), .stallCount(stall_cnt), .flushCount(flush_cnt));
`else
    hazard_ctrl #(.ZERO_REG(5'd31)) dut (.clk(clk), .reset(reset), .hz(hz));
`endif

    always #5 clk = ~clk;

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        reset            = t.rst;
        hz.fwdEn_ID      = t.fwd;
        hz.Rn_ID         = t.rn;
        hz.Rm_ID         = t.rm;
        hz.Rd_ID         = t.rd;
        hz.cbz_ID        = t.cbz;
        hz.bcond_ID      = t.bcond;
        hz.brTaken_ID    = t.br;
        hz.MemRead_EX    = t.mr_ex;
        hz.RegWrite_EX   = t.rw_ex;
        hz.flagSet_EX    = t.fs_ex;
        hz.targetReg_EX  = t.tr_ex;
        hz.MemRead_MEM   = t.mr_mem;
        hz.targetReg_MEM = t.tr_mem;
        #1;
        act = {hz.PCWrite, hz.IFID_write, hz.IFID_flush, hz.IDEX_bubble, hz.stall};
        n_vec++;
        if (act !== t.exp) begin
            n_bad++;
            $display("FAIL vec%0d {pcw,ifw,flush,bubble,stall}: got %b want %b", idx, act, t.exp);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic check_cnt(input string name, input logic [3:0] s, input logic [3:0] f);
        n_vec++;
        if (stall_cnt !== s || flush_cnt !== f) begin
            n_bad++;
            $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     name, stall_cnt, flush_cnt, s, f);
        end
    endtask
`endif

    initial begin
        //            rst fwd   rn rm rd cbz bc br mrE rwE fsE trE mrM trM exp
        v.push_back('{1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  RSTO}); // 0 reset
        v.push_back('{0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  RUNO}); // 1 idle
        v.push_back('{0, 2'b11, 4, 3, 0, 0, 0, 0, 1, 1, 0, 3,  0, 0,  STL});  // 2 load-use Rm
        v.push_back('{0, 2'b11, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3,  RUNO}); // 3 load in MEM
        v.push_back('{0, 2'b00, 0, 0, 7, 1, 0, 0, 1, 1, 0, 7,  0, 0,  STL});  // 4 CBZ after LDUR
        v.push_back('{0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0,  STL});  // 5 HOLD ignores br
        v.push_back('{0, 2'b00, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0,  RUNO}); // 6 CBZ resolves
        v.push_back('{0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 1, 1, 2,  0, 0,  STL});  // 7 ADDS + B.cond
        v.push_back('{0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0,  FLSH}); // 8 taken flush
        v.push_back('{0, 2'b11, 31,31,0, 0, 0, 0, 1, 1, 0, 31, 0, 0,  RUNO}); // 9 LDUR XZR
        v.push_back('{0, 2'b01, 2, 0, 9, 0, 0, 0, 1, 1, 0, 9,  0, 0,  STL});  // 10 STUR data
        v.push_back('{0, 2'b00, 0, 0, 5, 1, 0, 0, 0, 1, 0, 5,  0, 0,  STL});  // 11 CBZ after ALU
        v.push_back('{0, 2'b00, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0,  1, 6,  STL});  // 12 CBZ, load in MEM
        v.push_back('{0, 2'b00, 0, 0, 31,1, 0, 0, 1, 1, 0, 31, 1, 31, RUNO}); // 13 CBZ XZR
        v.push_back('{0, 2'b10, 9, 8, 0, 0, 0, 0, 1, 1, 0, 8,  0, 0,  RUNO}); // 14 Rm unused
        v.push_back('{0, 2'b00, 8, 0, 0, 0, 0, 0, 1, 1, 0, 8,  0, 0,  RUNO}); // 15 no sources
        v.push_back('{0, 2'b11, 1, 2, 3, 0, 0, 0, 1, 1, 0, 3,  0, 0,  RUNO}); // 16 Rd not source
        v.push_back('{0, 2'b11, 3, 4, 0, 0, 0, 1, 0, 1, 0, 3,  0, 0,  FLSH}); // 17 ALU fwd + br
        v.push_back('{0, 2'b10, 6, 0, 0, 0, 0, 1, 1, 1, 0, 6,  0, 0,  STL});  // 18 stall beats flush
        v.push_back('{0, 2'b00, 0, 0, 4, 1, 0, 0, 1, 1, 0, 4,  0, 0,  STL});  // 19 enter HOLD
        v.push_back('{1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  RSTO}); // 20 reset in HOLD
        v.push_back('{0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  RUNO}); // 21 back in RUN
        v.push_back('{0, 2'b00, 0, 0, 5, 1, 0, 0, 1, 1, 0, 6,  0, 0,  RUNO}); // 22 CBZ other reg
        v.push_back('{0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2,  0, 0,  STL});  // 23 flags, not taken
        v.push_back('{0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2,  0, 0,  FLSH}); // 24 flags w/o B.cond
        for (int i = 0; i < v.size(); i++) apply(v[i], i);
`ifdef HAZARD_PERF_EN
        // scenarios 1-3 after a fresh reset: 4 stall cycles, 1 flush cycle
        for (int i = 0; i <= 8; i++) apply(v[i], i);
        apply(v[1], 1);
        check_cnt("scenarios", 4'd4, 4'd1);
        for (int i = 0; i < 20; i++) apply(v[11], 11);
        for (int i = 0; i < 20; i++) apply(v[8], 8);
        apply(v[1], 1);
        check_cnt("saturate", 4'd15, 4'd15);
        apply(v[0], 0);
        apply(v[1], 1);
        check_cnt("cleared", 4'd0, 4'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
